// File: rtl/aes_rx.sv
// Byte-to-block receiver: assembles 16 strobed bytes (MSB-first) into a 128-bit block for a downstream FIFO.
// Latency: wr asserts in the cycle after the edge that accepts byte 15 (two edges after its strobe is sampled).
// Backpressure: full stalls the single pending block; a block completing while one is still pending is dropped and sets overflow.
module aes_rx #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [7:0]   rx,
    input  logic         shakehand,
    input  logic         full,
    input  logic         clr,
    output logic [127:0] data,
    output logic         wr,
    output logic         overflow,
    output logic         err,
    output logic         busy
);

    localparam logic [7:0] IDLE_MAX = 8'(TIMEOUT - 1);

    // Assembly side only; the pending output (PEND) is tracked by out_valid_q so
    // a new block can be gathered while the previous one waits on full.
    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } asm_state_t;

    asm_state_t   state_q, state_d;
    logic [7:0]   rx_q, rx_d;
    logic         hs_q, hs_d;
    logic         hs_prev_q, hs_prev_d;
    logic [119:0] asm_q, asm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [7:0]   idle_q, idle_d;
    logic [127:0] data_q, data_d;
    logic         out_valid_q, out_valid_d;
    logic         overflow_q, overflow_d;
    logic         err_q, err_d;
    logic         byte_acc;
    logic         drop;

    assign byte_acc = en & (hs_q ^ hs_prev_q);
    assign wr       = out_valid_q & ~full & en;
    assign data     = data_q;
    assign overflow = overflow_q;
    assign err      = err_q;
    assign busy     = (cnt_q != 4'd0);

    always_comb begin
        rx_d        = rx_q;
        hs_d        = hs_q;
        hs_prev_d   = hs_prev_q;
        asm_d       = asm_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        data_d      = data_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        err_d       = err_q;
        drop        = 1'b0;
        if (en) begin
            rx_d      = rx;
            hs_d      = shakehand;
            hs_prev_d = hs_q;
            err_d     = 1'b0;
            if (wr) begin
                out_valid_d = 1'b0;
            end
            if (byte_acc) begin
                asm_d  = {asm_q[111:0], rx_q};
                cnt_d  = cnt_q + 4'd1;
                idle_d = 8'd0;
                if (cnt_q == 4'd15) begin
                    // Replacing a block only works if the old one leaves this cycle.
                    if (out_valid_q && !wr) begin
                        drop = 1'b1;
                    end else begin
                        data_d      = {asm_q, rx_q};
                        out_valid_d = 1'b1;
                    end
                end
            end else if (state_q == ST_RECV) begin
                if (idle_q == IDLE_MAX) begin
                    cnt_d  = 4'd0;
                    idle_d = 8'd0;
                    err_d  = 1'b1;
                end else begin
                    idle_d = idle_q + 8'd1;
                end
            end else begin
                idle_d = 8'd0;
            end
            if (clr) begin
                overflow_d = 1'b0;
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
        state_d = (cnt_d != 4'd0) ? ST_RECV : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rx_q        <= 8'd0;
            hs_q        <= 1'b0;
            hs_prev_q   <= 1'b0;
            asm_q       <= '0;
            cnt_q       <= 4'd0;
            idle_q      <= 8'd0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_q        <= rx_d;
            hs_q        <= hs_d;
            hs_prev_q   <= hs_prev_d;
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_aes_rx.sv
// Directed bench for aes_rx: block assembly, backpressure, overflow, timeout, clock enable and reset.
module tb_aes_rx;

    localparam int TO = 8;
    localparam logic [127:0] BLK0 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] BLK1 = 128'h101112131415161718191A1B1C1D1E1F;
    localparam logic [127:0] BLK2 = 128'h202122232425262728292A2B2C2D2E2F;
    localparam logic [127:0] BLK3 = 128'h303132333435363738393A3B3C3D3E3F;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [7:0]   rx;
    logic         shakehand;
    logic         full;
    logic         clr;
    logic [127:0] data;
    logic         wr;
    logic         overflow;
    logic         err;
    logic         busy;

    int n_chk  = 0;
    int n_pass = 0;
    int errs;

    aes_rx #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rx        (rx),
        .shakehand (shakehand),
        .full      (full),
        .clr       (clr),
        .data      (data),
        .wr        (wr),
        .overflow  (overflow),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx        = b;
        shakehand = ~shakehand;
        step();
    endtask

    task automatic send_blk(input logic [7:0] base);
        for (int i = 0; i < 16; i++) send_byte(base + 8'(i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; rx = 8'd0; shakehand = 1'b0; full = 1'b0; clr = 1'b0;
        step(); step();
        check("rst_data", data, '0);
        check("rst_wr", 128'(wr), 128'd0);
        check("rst_ovf", 128'(overflow), 128'd0);
        check("rst_err", 128'(err), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        rst_n = 1'b1;
        step();

        // Basic block, two edges after the last strobe is sampled
        send_blk(8'h00);
        check("t1_wr_early", 128'(wr), 128'd0);
        step();
        check("t1_wr", 128'(wr), 128'd1);
        check("t1_data", data, BLK0);
        step();
        check("t1_wr_once", 128'(wr), 128'd0);
        check("t1_busy", 128'(busy), 128'd0);

        // Backpressure for 5 cycles
        full = 1'b1;
        send_blk(8'h00);
        step();
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            if (wr) errs++;
            step();
        end
        check("t2_wr_held", 128'(errs), 128'd0);
        full = 1'b0;
        #1;
        check("t2_wr", 128'(wr), 128'd1);
        check("t2_data", data, BLK0);
        check("t2_ovf", 128'(overflow), 128'd0);
        step();
        check("t2_wr_once", 128'(wr), 128'd0);

        // Overflow while pending
        full = 1'b1;
        send_blk(8'h00);
        step();
        send_blk(8'h10);
        step();
        check("t3_ovf", 128'(overflow), 128'd1);
        check("t3_wr_full", 128'(wr), 128'd0);
        full = 1'b0;
        #1;
        check("t3_wr", 128'(wr), 128'd1);
        check("t3_data", data, BLK0);
        step();
        check("t3_wr_once", 128'(wr), 128'd0);
        check("t3_ovf_sticky", 128'(overflow), 128'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t3_clr", 128'(overflow), 128'd0);

        // Timeout abort after 5 bytes
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
        errs = 0;
        for (int i = 0; i < TO + 4; i++) begin
            step();
            if (i == 0) check("t4_busy", 128'(busy), 128'd1);
            if (err) errs++;
        end
        check("t4_err_once", 128'(errs), 128'd1);
        check("t4_busy_drop", 128'(busy), 128'd0);
        send_blk(8'h20);
        step();
        check("t4_wr", 128'(wr), 128'd1);
        check("t4_data", data, BLK2);
        step();

        // Clock enable hold mid-block and on a pending write
        for (int i = 0; i < 8; i++) send_byte(8'(i));
        en = 1'b0;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (err) errs++;
        end
        check("t5_no_err", 128'(errs), 128'd0);
        check("t5_busy", 128'(busy), 128'd1);
        en = 1'b1;
        for (int i = 8; i < 16; i++) send_byte(8'(i));
        step();
        en = 1'b0;
        #1;
        check("t5_wr_en0", 128'(wr), 128'd0);
        step();
        check("t5_wr_en0b", 128'(wr), 128'd0);
        en = 1'b1;
        #1;
        check("t5_wr", 128'(wr), 128'd1);
        check("t5_data", data, BLK0);
        step();
        check("t5_wr_once", 128'(wr), 128'd0);

        // Reset with a pending block, overflow set and a partial block
        full = 1'b1;
        send_blk(8'h00);
        step();
        send_blk(8'h10);
        step();
        for (int i = 0; i < 10; i++) send_byte(8'h50 + 8'(i));
        #2;
        rst_n = 1'b0;
        full = 1'b0;
        shakehand = 1'b0;
        #1;
        check("t6_data", data, '0);
        check("t6_wr", 128'(wr), 128'd0);
        check("t6_ovf", 128'(overflow), 128'd0);
        check("t6_busy", 128'(busy), 128'd0);
        step();
        rst_n = 1'b1;
        step();
        check("t6_wr_after", 128'(wr), 128'd0);
        check("t6_busy_after", 128'(busy), 128'd0);
        send_blk(8'h30);
        step();
        check("t6_wr_new", 128'(wr), 128'd1);
        check("t6_data_new", data, BLK3);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
